// File: rtl/i2s_grid_node.sv
// Serial grid-bus node: parses each row header, derives its own slot position from
// (x, y), and extracts the CHANNELS consecutive payload words addressed to it.
module i2s_grid_node #(
    parameter  int SLOT_W   = 16,
    parameter  int COORD_W  = 4,
    parameter  int ROW_W    = 6,
    parameter  int CHANNELS = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               i2s_clk,
    input  logic               rst_n,
    input  logic               i2s_data,
    input  logic               i2s_sync,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [SLOT_W-1:0]  data_out,
    output logic [CH_W-1:0]    data_ch,
    output logic               data_valid,
    output logic [ROW_W-1:0]   row_num,
    output logic               hdr_valid,
    output logic               frame_done,
    output logic               frame_err,
    output logic               addr_err
);

    localparam int SC_W = 2*COORD_W + CH_W;
    localparam int BC_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(SLOT_W - 1);
    localparam logic [SC_W-1:0] CH_CNT   = SC_W'(CHANNELS);

    typedef enum logic {HEADER, PAYLOAD} state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  shift_q, shift_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SC_W-1:0]    slot_cnt_q, slot_cnt_d;
    logic [SC_W-1:0]    base_q, last_slot_q, slot_off;
    logic [SC_W-1:0]    base_d, last_slot_d;
    logic [COORD_W-1:0] hdr_nx, hdr_ny;
    logic [COORD_W:0]   nx, ny;
    logic               hdr_done, slot_done, frame_end, sync_err;
    logic               owned, hdr_excl;

    assign shift_d = {shift_q[SLOT_W-2:0], i2s_data};

    // Header fields are decoded from the word including the bit sampled this edge.
    assign hdr_nx   = shift_d[SLOT_W-1 -: COORD_W];
    assign hdr_ny   = shift_d[SLOT_W-1-COORD_W -: COORD_W];
    assign nx       = {1'b0, hdr_nx} + (COORD_W+1)'(1);
    assign ny       = {1'b0, hdr_ny} + (COORD_W+1)'(1);
    assign hdr_excl = (x > hdr_nx) || (y > hdr_ny);

    // Modular arithmetic keeps total-1 exact even when the product wraps SC_W.
    assign last_slot_d = SC_W'(nx) * SC_W'(ny) * CH_CNT - SC_W'(1);
    assign base_d      = (SC_W'(y) * SC_W'(nx) + SC_W'(x)) * CH_CNT;

    assign slot_off = slot_cnt_q - base_q;
    assign owned    = !addr_err && (slot_cnt_q >= base_q) && (slot_off < CH_CNT);

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) state_q <= HEADER;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + BC_W'(1);
        slot_cnt_d = slot_cnt_q;
        hdr_done   = 1'b0;
        slot_done  = 1'b0;
        frame_end  = 1'b0;
        sync_err   = 1'b0;
        if (i2s_sync) begin
            // The sync bit itself is header MSB, so one header bit is already in.
            sync_err   = (state_q == PAYLOAD) || (bit_cnt_q != '0);
            state_d    = HEADER;
            bit_cnt_d  = BC_W'(1);
            slot_cnt_d = '0;
        end else if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (state_q == HEADER) begin
                hdr_done   = 1'b1;
                state_d    = PAYLOAD;
                slot_cnt_d = '0;
            end else begin
                slot_done = 1'b1;
                if (slot_cnt_q == last_slot_q) begin
                    frame_end  = 1'b1;
                    state_d    = HEADER;
                    slot_cnt_d = '0;
                end else begin
                    slot_cnt_d = slot_cnt_q + SC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            base_q      <= '0;
            last_slot_q <= '0;
            data_out    <= '0;
            data_ch     <= '0;
            data_valid  <= 1'b0;
            row_num     <= '0;
            hdr_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            hdr_valid  <= hdr_done;
            frame_done <= frame_end;
            frame_err  <= sync_err;
            data_valid <= slot_done && owned;
            if (hdr_done) begin
                row_num     <= shift_d[ROW_W-1:0];
                addr_err    <= hdr_excl;
                base_q      <= base_d;
                last_slot_q <= last_slot_d;
            end
            if (slot_done && owned) begin
                data_out <= shift_d;
                data_ch  <= slot_off[CH_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_i2s_grid_node.sv
// Scoreboard bench for i2s_grid_node: stimulus pushes expected strobes with their
// edge number; per-DUT monitors pop and compare whenever a strobe appears.
module tb_i2s_grid_node;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst3_n = 1'b0;
    logic        i2s_data = 1'b0;
    logic        i2s_sync = 1'b0;
    logic [3:0]  x = 4'd1, y = 4'd2;
    logic [3:0]  x3 = 4'd1, y3 = 4'd1;

    logic [15:0] data_out, data_out3;
    logic [0:0]  data_ch;
    logic [1:0]  data_ch3;
    logic [5:0]  row_num, row_num3;
    logic        data_valid, hdr_valid, frame_done, frame_err, addr_err;
    logic        data_valid3, hdr_valid3, frame_done3, frame_err3, addr_err3;

    i2s_grid_node dut (
        .i2s_clk(clk), .rst_n(rst_n), .i2s_data(i2s_data), .i2s_sync(i2s_sync),
        .x(x), .y(y), .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid),
        .row_num(row_num), .hdr_valid(hdr_valid), .frame_done(frame_done),
        .frame_err(frame_err), .addr_err(addr_err)
    );

    i2s_grid_node #(.CHANNELS(3)) dut3 (
        .i2s_clk(clk), .rst_n(rst3_n), .i2s_data(i2s_data), .i2s_sync(i2s_sync),
        .x(x3), .y(y3), .data_out(data_out3), .data_ch(data_ch3), .data_valid(data_valid3),
        .row_num(row_num3), .hdr_valid(hdr_valid3), .frame_done(frame_done3),
        .frame_err(frame_err3), .addr_err(addr_err3)
    );

    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    int checks = 0;
    int failures = 0;
    int last_edge = 0;
    logic tgt3 = 1'b0;

    typedef enum int {EV_HDR, EV_DATA, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          at_edge;
        logic [15:0] val;
        logic [5:0]  aux;
    } exp_t;

    exp_t q[$];
    exp_t q3[$];

    task automatic pushExp(input ev_kind_t k, input logic [15:0] v, input logic [5:0] a);
        exp_t e;
        e.kind = k; e.at_edge = last_edge; e.val = v; e.aux = a;
        if (tgt3) q3.push_back(e);
        else      q.push_back(e);
    endtask

    task automatic flushStale(input bit which, input string tag);
        exp_t f;
        while ((which ? q3.size() : q.size()) > 0) begin
            f = which ? q3[0] : q[0];
            if (f.at_edge >= ec) break;
            checks++;
            failures++;
            $display("[TB] FAIL %s_missing_%s: actual none by edge %0d, required at edge %0d val=%h aux=%h",
                     tag, f.kind.name(), ec, f.at_edge, f.val, f.aux);
            if (which) void'(q3.pop_front());
            else       void'(q.pop_front());
        end
    endtask

    task automatic expectEvent(input bit which, input ev_kind_t k, input logic [15:0] v,
                               input logic [5:0] a, input string tag);
        exp_t f;
        checks++;
        if ((which ? q3.size() : q.size()) == 0) begin
            failures++;
            $display("[TB] FAIL %s_unexpected_%s: actual edge %0d val=%h aux=%h, required no strobe",
                     tag, k.name(), ec, v, a);
            return;
        end
        if (which) f = q3.pop_front();
        else       f = q.pop_front();
        if (f.kind != k || f.at_edge != ec || f.val !== v || f.aux !== a) begin
            failures++;
            $display("[TB] FAIL %s_%s: actual %s edge %0d val=%h aux=%h, required %s edge %0d val=%h aux=%h",
                     tag, f.kind.name(), k.name(), ec, v, a, f.kind.name(), f.at_edge, f.val, f.aux);
        end
    endtask

    always @(negedge clk) begin
        flushStale(1'b0, "dut");
        if (hdr_valid)  expectEvent(1'b0, EV_HDR, 16'(row_num), {5'b0, addr_err}, "dut");
        if (data_valid) expectEvent(1'b0, EV_DATA, data_out, {5'b0, data_ch}, "dut");
        if (frame_done) expectEvent(1'b0, EV_DONE, 16'h0, 6'h0, "dut");
        if (frame_err)  expectEvent(1'b0, EV_ERR, 16'h0, 6'h0, "dut");
    end

    always @(negedge clk) begin
        flushStale(1'b1, "dut3");
        if (hdr_valid3)  expectEvent(1'b1, EV_HDR, 16'(row_num3), {5'b0, addr_err3}, "dut3");
        if (data_valid3) expectEvent(1'b1, EV_DATA, data_out3, {4'b0, data_ch3}, "dut3");
        if (frame_done3) expectEvent(1'b1, EV_DONE, 16'h0, 6'h0, "dut3");
        if (frame_err3)  expectEvent(1'b1, EV_ERR, 16'h0, 6'h0, "dut3");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    task automatic sendBit(input logic b, input logic s);
        @(negedge clk);
        i2s_data  = b;
        i2s_sync  = s;
        last_edge = ec + 1;
    endtask

    // Header, then pay_bits payload bits; DONE is expected only if the frame completes.
    task automatic applyStimulus(input logic [15:0] hdr, input logic sync, input logic exp_err,
                                 input logic exp_aerr, input int nslots, input int pay_bits,
                                 input int own_slot, input int nch,
                                 input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 16; i++) begin
            sendBit(hdr[15-i], sync && (i == 0));
            if (i == 0 && exp_err) pushExp(EV_ERR, 16'h0, 6'h0);
        end
        pushExp(EV_HDR, {10'b0, hdr[5:0]}, {5'b0, exp_aerr});
        for (int b = 0; b < pay_bits; b++) begin
            int slot;
            int bi;
            logic mine;
            logic [15:0] w;
            slot = b / 16;
            bi   = 15 - (b % 16);
            mine = (own_slot >= 0) && (slot >= own_slot) && (slot < own_slot + nch);
            w    = 16'h5A00 + 16'(slot);
            if (mine) w = (slot == own_slot) ? w0 : (slot == own_slot + 1) ? w1 : w2;
            sendBit(w[bi], 1'b0);
            if (bi == 0 && mine && !exp_aerr) pushExp(EV_DATA, w, 6'(slot - own_slot));
            if (b == nslots*16 - 1) pushExp(EV_DONE, 16'h0, 6'h0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_out"}, data_out, 16'h0);
        checkOutput({tag, "_data_ch"}, 16'(data_ch), 16'h0);
        checkOutput({tag, "_data_valid"}, 16'(data_valid), 16'h0);
        checkOutput({tag, "_row_num"}, 16'(row_num), 16'h0);
        checkOutput({tag, "_hdr_valid"}, 16'(hdr_valid), 16'h0);
        checkOutput({tag, "_frame_done"}, 16'(frame_done), 16'h0);
        checkOutput({tag, "_frame_err"}, 16'(frame_err), 16'h0);
        checkOutput({tag, "_addr_err"}, 16'(addr_err), 16'h0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] 4x4 grid, node (1,2), aligned sync on first header");
        applyStimulus(16'h3305, 1'b1, 1'b0, 1'b0, 16, 256, 9, 1, 16'hA5C3, 16'h0, 16'h0);

        $display("[TB] back-to-back frames, row 0 then row 1");
        applyStimulus(16'h3300, 1'b0, 1'b0, 1'b0, 16, 256, 9, 1, 16'h1234, 16'h0, 16'h0);
        applyStimulus(16'h3301, 1'b0, 1'b0, 1'b0, 16, 256, 9, 1, 16'hBEEF, 16'h0, 16'h0);

        $display("[TB] unaddressed node (3,3) in 2x2 grid");
        x = 4'd3; y = 4'd3;
        applyStimulus(16'h1100, 1'b0, 1'b0, 1'b1, 4, 64, -1, 1, 16'h0, 16'h0, 16'h0);
        checkOutput("addr_err_level", 16'(addr_err), 16'h1);
        x = 4'd1; y = 4'd2;

        $display("[TB] sync at payload bit 40, then aligned sync control");
        applyStimulus(16'h3302, 1'b0, 1'b0, 1'b0, 16, 40, 9, 1, 16'hFFFF, 16'h0, 16'h0);
        applyStimulus(16'h3303, 1'b1, 1'b1, 1'b0, 16, 256, 9, 1, 16'h0F0F, 16'h0, 16'h0);
        applyStimulus(16'h3304, 1'b1, 1'b0, 1'b0, 16, 256, 9, 1, 16'h3C3C, 16'h0, 16'h0);

        $display("[TB] reset during owned slot");
        applyStimulus(16'h3305, 1'b0, 1'b0, 1'b0, 16, 150, 9, 1, 16'h7777, 16'h0, 16'h0);
        checkOutput("row_before_reset", 16'(row_num), 16'h5);
        checkOutput("data_before_reset", data_out, 16'h3C3C);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(16'h3307, 1'b0, 1'b0, 1'b0, 16, 256, 9, 1, 16'h6A6A, 16'h0, 16'h0);
        repeat (4) @(negedge clk);

        $display("[TB] CHANNELS=3, 2x2 grid, node (1,1)");
        rst_n = 1'b0;
        tgt3  = 1'b1;
        @(posedge clk);
        #1 rst3_n = 1'b1;
        applyStimulus(16'h1104, 1'b0, 1'b0, 1'b0, 12, 192, 9, 3, 16'h1111, 16'h2222, 16'h3333);
        repeat (4) @(negedge clk);

        checkOutput("dut_queue_left", 16'(q.size()), 16'h0);
        checkOutput("dut3_queue_left", 16'(q3.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
